// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-port arbiter between pipeline and a one-entry long-latency result buffer with anti-starvation.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs showing the buffer contents.
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_data,
  input  logic        lat_valid,
  input  logic [4:0]  lat_rd,
  input  logic [63:0] lat_data,
  output logic        lat_ready,
  output logic        stall_req,
`ifdef WB_FWD_EN
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [63:0] fwd_data,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [63:0] rf_data
);
  typedef enum logic [1:0] {IDLE, HELD, FORCE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] data_q, data_d;
  logic        pipe_w, accept, starved;
  assign lat_ready = state_q == IDLE;
  assign stall_req = state_q == FORCE;
  assign pipe_w    = pipe_valid && pipe_rd != 5'd0;
  assign accept    = lat_valid && lat_ready && lat_rd != 5'd0;
  assign starved   = {1'b0, cnt_q} + 5'd1 >= 5'(STARVE_MAX);
  assign rf_we     = we_q;
  assign rf_rd     = rd_q;
  assign rf_data   = data_q;
`ifdef WB_FWD_EN
  assign fwd_valid = state_q != IDLE;
  assign fwd_rd    = buf_rd_q;
  assign fwd_data  = buf_data_q;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    we_d       = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        if (pipe_w) begin
          we_d   = 1'b1;
          rd_d   = pipe_rd;
          data_d = pipe_data;
        end
        if (accept) begin
          state_d    = HELD;
          cnt_d      = 4'd0;
          buf_rd_d   = lat_rd;
          buf_data_d = lat_data;
        end
      end
      HELD: begin
        we_d    = 1'b1;
        rd_d    = pipe_w ? pipe_rd : buf_rd_q;
        data_d  = pipe_w ? pipe_data : buf_data_q;
        cnt_d   = !pipe_w ? 4'd0 : (cnt_q == 4'hf ? cnt_q : cnt_q + 4'd1);
        state_d = !pipe_w ? IDLE : (starved ? FORCE : HELD);
      end
      default: begin
        we_d    = 1'b1;
        rd_d    = buf_rd_q;
        data_d  = buf_data_q;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      buf_rd_q   <= 5'd0;
      buf_data_q <= 64'd0;
      we_q       <= 1'b0;
      rd_q       <= 5'd0;
      data_q     <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of wb_arbiter writeback arbitration, starvation forcing and reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, lat_valid, lat_ready, stall_req, rf_we;
  logic [4:0]  pipe_rd, lat_rd, rf_rd;
  logic [63:0] pipe_data, lat_data, rf_data;
  int tests = 0;
  int fails = 0;
  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data),
    .lat_ready(lat_ready), .stall_req(stall_req),
`ifdef WB_FWD_EN
    .fwd_valid(), .fwd_rd(), .fwd_data(),
`endif
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [63:0] data);
    chk({tag, "_we"}, 64'(rf_we), 64'd1);
    chk({tag, "_rd"}, 64'(rf_rd), 64'(rd));
    chk({tag, "_data"}, rf_data, data);
  endtask
  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 64'd0;
    lat_valid = 1'b0; lat_rd = 5'd0; lat_data = 64'd0;
    tick();
    tick();
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", rf_data, 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_ready", 64'(lat_ready), 64'd1);
    rst = 1'b0;
    // single latent result on an idle pipe: visible two cycles after offer
    lat_valid = 1'b1; lat_rd = 5'd5; lat_data = 64'hDEAD;
    chk("lat_ready_t", 64'(lat_ready), 64'd1);
    tick();
    lat_valid = 1'b0;
    chk("lat_t1_we", 64'(rf_we), 64'd0);
    chk("lat_t1_ready", 64'(lat_ready), 64'd0);
    chk("lat_t1_stall", 64'(stall_req), 64'd0);
    tick();
    chk_wr("lat_t2", 5'd5, 64'hDEAD);
    chk("lat_t2_ready", 64'(lat_ready), 64'd1);
    chk("lat_t2_stall", 64'(stall_req), 64'd0);
    tick();
    chk("lat_t3_we", 64'(rf_we), 64'd0);
    // continuous pipeline traffic starves the buffer until FORCE
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h33;
    lat_valid = 1'b1; lat_rd = 5'd7; lat_data = 64'h77;
    tick();
    lat_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("starve_t%0d_stall", i), 64'(stall_req), 64'd0);
      chk_wr($sformatf("starve_t%0d", i), 5'd3, 64'h33);
      tick();
    end
    chk("starve_t5_stall", 64'(stall_req), 64'd1);
    chk("starve_t5_ready", 64'(lat_ready), 64'd0);
    chk_wr("starve_t5", 5'd3, 64'h33);
    tick();
    chk("starve_t6_stall", 64'(stall_req), 64'd0);
    chk_wr("starve_t6", 5'd7, 64'h77);
    tick();
    pipe_valid = 1'b0;
    chk_wr("starve_t7", 5'd3, 64'h33);
    tick();
    chk("starve_t8_we", 64'(rf_we), 64'd0);
    // simultaneous offers; a new offer during the drain cycle must wait
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h99;
    lat_valid = 1'b1; lat_rd = 5'd10; lat_data = 64'hAA;
    tick();
    pipe_valid = 1'b0;
    lat_rd = 5'd11; lat_data = 64'hBB;
    chk_wr("both_t1", 5'd9, 64'h99);
    chk("both_t1_ready", 64'(lat_ready), 64'd0);
    tick();
    chk_wr("both_t2", 5'd10, 64'hAA);
    chk("both_t2_ready", 64'(lat_ready), 64'd1);
    tick();
    lat_valid = 1'b0;
    chk("both_t3_we", 64'(rf_we), 64'd0);
    chk("both_t3_ready", 64'(lat_ready), 64'd0);
    tick();
    chk_wr("both_t4", 5'd11, 64'hBB);
    tick();
    chk("both_t5_we", 64'(rf_we), 64'd0);
    // register zero from either source never writes
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 64'h55;
    lat_valid = 1'b1; lat_rd = 5'd0; lat_data = 64'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("zero_%0d_we", i), 64'(rf_we), 64'd0);
      chk($sformatf("zero_%0d_ready", i), 64'(lat_ready), 64'd1);
    end
    // reset in FORCE discards the buffered result
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h34;
    lat_valid = 1'b1; lat_rd = 5'd12; lat_data = 64'hCC;
    tick();
    lat_valid = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk("frst_stall", 64'(stall_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pipe_valid = 1'b0;
    chk("frst_we", 64'(rf_we), 64'd0);
    chk("frst_rd", 64'(rf_rd), 64'd0);
    chk("frst_data", rf_data, 64'd0);
    chk("frst_stall0", 64'(stall_req), 64'd0);
    chk("frst_ready", 64'(lat_ready), 64'd1);
    tick();
    chk("frst_t1_we", 64'(rf_we), 64'd0);
    tick();
    chk("frst_t2_we", 64'(rf_we), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 STARVE_MAX, default 4, max consecutive cycles a buffered long-latency result may lose arbitration (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pipe_valid  input  1  MA/WB stage holds a writeback.
REQ-005 pipe_rd  input  5  destination register of pipeline writeback.
REQ-006 pipe_data  input  64  pipeline writeback value.
REQ-007 lat_valid  input  1  long-latency unit (divider / load-miss) offers a result.
REQ-008 lat_rd  input  5  destination of offered result.
REQ-009 lat_data  input  64  offered result value.
REQ-010 lat_ready  output  1  arbiter accepts offered result this cycle.
REQ-011 stall_req  output  1  freeze request to MA/WB stage register and upstream.
REQ-012 rf_we  output  1  register-file write enable, registered.
REQ-013 rf_rd  output  5  register-file write index, registered.
REQ-014 rf_data  output  64  register-file write data, registered.

Function
REQ-015 One-entry buffer (valid, rd, data) holds accepted long-latency result; lat_ready = ~buffer valid.
REQ-016 Accept: lat_valid & lat_ready at edge loads buffer; lat_rd==0 accepted and discarded, buffer stays empty.
REQ-017 States: IDLE (buffer empty), HELD (buffer full, waiting), FORCE (buffer full, pipeline frozen).
REQ-018 IDLE: pipe_valid & pipe_rd!=0 -> write pipeline next edge; accept into buffer -> HELD, starve counter = 0.
REQ-019 HELD, pipe_valid & pipe_rd!=0: pipeline wins, counter +1; counter reaching STARVE_MAX -> FORCE.
REQ-020 HELD, no pipeline write: buffer written next edge, buffer cleared, -> IDLE.
REQ-021 FORCE: stall_req=1 (decoded from registered state only, no combinational input path); buffer written at edge, cleared, -> IDLE; held pipeline value written the following cycle.
REQ-022 stall_req=0 in IDLE and HELD.
REQ-023 Write latency: selected source appears on rf_we/rf_rd/rf_data exactly one cycle after arbitration; rf_we=0 when nothing selected.
REQ-024 Pipeline writes with pipe_rd==0 never assert rf_we and count as "no pipeline write" for arbitration.
REQ-025 Buffer drain and new acceptance in same cycle not permitted: lat_ready low in cycle buffer drains; new acceptance earliest next cycle.
REQ-026 At most one rf write per cycle; no pipeline or latent result dropped or duplicated.
REQ-027 Starve counter 4 bits, saturating, cleared on every buffer drain.

Reset
REQ-028 rst high at edge: state IDLE, buffer invalid, counter 0, rf_we=0, rf_rd=0, rf_data=0, stall_req=0; lat_ready=1 from first cycle after reset.
REQ-029 Reset mid-FORCE or mid-HELD discards buffered result without write; no rf_we in the cycle following reset.

Configuration
REQ-030 Macro WB_FWD_EN defined: extra outputs fwd_valid (1), fwd_rd (5), fwd_data (64) expose buffer contents combinationally for decode bypass; fwd_valid = buffer valid.
REQ-031 WB_FWD_EN undefined: forwarding ports absent; all other behaviour identical.

Verification
REQ-032 Idle pipe; lat_valid rd=5 data=0xDEAD at cycle t -> rf_we, rf_rd=5, rf_data=0xDEAD at t+2; stall_req never high.
REQ-033 pipe_valid rd=3 every cycle, STARVE_MAX=4, lat rd=7 accepted at t -> stall_req high at t+5 only; rd=7 written t+6; held pipe value written t+7.
REQ-034 pipe_valid and lat_valid same cycle, buffer empty -> pipeline written next cycle; latent buffered, lat_ready low until drain.
REQ-035 lat rd=0 and pipe rd=0 stimulus -> rf_we never asserted, lat_ready stays high.
REQ-036 rst asserted during FORCE -> buffered value never written, all outputs zero next cycle, lat_ready=1.
